// File: rtl/serial_parity_checker.sv
// Framed serial parity checker: assembles DATA_BITS data bits (LSB first), checks the
// trailing parity bit, and reports per-frame done/error pulses plus a saturating error count.
module serial_parity_checker #(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_ODD = 1'b0,
    parameter int ERR_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 x,
    input  logic                 x_valid,
    output logic                 z,
    output logic                 busy,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_done,
    output logic                 parity_err,
    output logic [ERR_W-1:0]     err_count
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 frame_done_q, frame_done_d;
    logic                 parity_err_q, parity_err_d;
    logic [ERR_W-1:0]     err_count_q, err_count_d;
    logic                 z_q, z_d;
    logic                 busy_q, busy_d;
    logic                 mismatch;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        frame_done_d = 1'b0;
        parity_err_d = 1'b0;
        err_count_d  = err_count_q;
        mismatch     = 1'b0;

        // frame_start wins in every state; an open frame is dropped without reporting
        if (frame_start) begin
            state_d = DATA;
            acc_d   = 1'b0;
            cnt_d   = '0;
            shift_d = '0;
        end else begin
            case (state_q)
                IDLE: ;
                DATA: begin
                    if (x_valid) begin
                        acc_d   = acc_q ^ x;
                        shift_d = shift_q | (DATA_BITS'(x) << cnt_q);
                        if (cnt_q == LAST_IDX) begin
                            state_d = PARITY;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (x_valid) begin
                        mismatch     = (x != (acc_q ^ PARITY_ODD));
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                        parity_err_d = mismatch;
                        data_out_d   = shift_q;
                        if (mismatch && (err_count_q != {ERR_W{1'b1}})) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        z_d    = acc_d ^ PARITY_ODD;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= 1'b0;
            cnt_q        <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            frame_done_q <= 1'b0;
            parity_err_q <= 1'b0;
            err_count_q  <= '0;
            z_q          <= PARITY_ODD;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            frame_done_q <= frame_done_d;
            parity_err_q <= parity_err_d;
            err_count_q  <= err_count_d;
            z_q          <= z_d;
            busy_q       <= busy_d;
        end
    end

    assign z          = z_q;
    assign busy       = busy_q;
    assign data_out   = data_out_q;
    assign frame_done = frame_done_q;
    assign parity_err = parity_err_q;
    assign err_count  = err_count_q;

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Parametrised successor to the single-bit serial parity generator.
- Receives a framed serial bit stream, LSB first, with a per-bit valid qualifier.
- Accumulates running parity over DATA_BITS data bits, checks the trailing parity bit against even or odd parity, and presents the assembled data word.
- Reports per-frame done/error pulses and keeps a saturating error counter; sits behind a serial receive front end.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 1..32.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.
- ERR_W, 8, width of err_count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- frame_start  input  1  one-cycle pulse opening a new frame; carries no data bit.
- x  input  1  serial bit; sampled only when x_valid = 1.
- x_valid  input  1  qualifies x this cycle.
- z  output  1  registered running parity of data bits accepted in the current frame, XOR PARITY_ODD.
- busy  output  1  high in DATA and PARITY states.
- data_out  output  DATA_BITS  last completed frame's data word; bit 0 = first bit received.
- frame_done  output  1  one-cycle pulse: frame completed.
- parity_err  output  1  one-cycle pulse coincident with frame_done when received parity mismatches.
- err_count  output  ERR_W  count of frames with parity_err; saturates at all-ones.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - Accumulator acc = 0, so z = PARITY_ODD.
  - busy, frame_done, parity_err = 0; data_out = 0; err_count = 0; bit counter = 0; shift register = 0.
- FSM states: IDLE, DATA, PARITY.
- IDLE:
  - frame_start = 1 -> DATA next cycle; acc, counter and shift register cleared.
  - x_valid is ignored.
- DATA:
  - Each cycle with x_valid = 1: acc <= acc ^ x; shift register loads x at bit index = counter; counter increments.
  - When the counter equals DATA_BITS-1 with x_valid = 1 -> PARITY.
  - Cycles with x_valid = 0 hold all state.
- PARITY:
  - With x_valid = 1: expected = acc ^ PARITY_ODD; mismatch = (x != expected).
  - Next cycle: frame_done = 1, parity_err = mismatch, data_out <= shift register, and err_count increments on mismatch unless already all-ones.
  - State returns to IDLE; the parity bit does not alter acc.
- Latency: frame_done is asserted 1 cycle after the cycle the parity bit is accepted.
- z updates 1 cycle after each accepted data bit. z holds its value through PARITY and IDLE until the next frame_start clears acc.
- frame_start priority:
  - In DATA or PARITY, frame_start overrides x_valid.
  - The current frame is abandoned: no frame_done, no err_count change, data_out unchanged. Restart proceeds as in IDLE.
- frame_done/parity_err are never asserted outside the post-PARITY cycle. Back-to-back frames are legal: frame_start may arrive in the frame_done cycle.
- DATA_BITS = 1: DATA lasts exactly one accepted bit.
- err_count at all-ones stays at all-ones; parity_err still pulses.
- busy = 1 exactly while the state is DATA or PARITY.

Test Plan:
- DATA_BITS=8, even; reset mid-DATA after 3 bits -> busy=0, z=0, err_count=0 immediately (asynchronously); next frame 0xA5 with parity 0 -> frame_done pulse, parity_err=0, data_out=8'hA5.
- Even; data 0x0B (LSB-first bits 1,1,0,1,0,0,0,0), parity bit 0 -> parity_err=1, err_count=1, data_out=8'h0B; z sequence after bits: 1,0,0,1,1,1,1,1.
- PARITY_ODD=1; data 0x0B with parity 0 -> no error; z resets to 1.
- Even; data 0x0F with x_valid gaps of 0-3 idle cycles between bits -> identical result as gapless: parity 0 accepted, no error.
- Even; frame_start after 5 data bits, then full frame 0x3C parity 0 -> single frame_done, data_out=8'h3C, no error, err_count unchanged.
- ERR_W=2; 5 consecutive bad-parity frames -> err_count 1,2,3,3,3; parity_err pulses all 5 times.
